// File: rtl/keypad_pkg.sv
// Shared types, key map and row/column helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        CONFIRM,
        PRESSED
    } state_t;

    typedef struct packed {
        logic       hit;
        logic       ghost;
        logic [1:0] row;
    } row_class_t;

    // Indexed {row, col}: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = E 0 F D
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [3:0] col_rotate(input logic [3:0] col);
        return {col[2:0], col[3]};
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] col);
        case (col)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Exactly one low row is a hit; several low rows is a ghost.
    function automatic row_class_t classify_rows(input logic [3:0] rows);
        row_class_t res;
        logic [2:0] n;
        res = '0;
        n   = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (!rows[i]) begin
                n       = n + 3'd1;
                res.row = 2'(i);
            end
        end
        res.hit   = (n == 3'd1);
        res.ghost = (n > 3'd1);
        return res;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser, resets to all-ones so idle pulled-up lines read inactive.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                meta_reg[gi] <= 1'b1;
                sync_reg[gi] <= 1'b1;
            end else begin
                meta_reg[gi] <= d[gi];
                sync_reg[gi] <= meta_reg[gi];
            end
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 keypad scanner: column rotation, debounced press/release and ghost rejection,
// producing a hex key code with a one-cycle valid strobe.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int DEBOUNCE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int              CW     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   LAST   = CW'(SCAN_DIV - 1);
    localparam logic [7:0]      DB_MAX = 8'(DEBOUNCE);

    logic [3:0]    row_s;
    logic [CW-1:0] slot_reg;
    logic [7:0]    db_reg;
    logic [1:0]    cand_row_reg;
    state_t        state_reg;
    logic [3:0]    col_reg;
    logic [3:0]    code_reg;
    logic          valid_reg;
    logic          held_reg;

    logic          slot_end;
    row_class_t    rc;
    logic [7:0]    db_inc;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_n),
        .q     (row_s)
    );

    assign slot_end = (slot_reg == LAST);
    assign rc       = classify_rows(row_s);
    assign db_inc   = db_reg + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_reg     <= '0;
            db_reg       <= 8'd0;
            cand_row_reg <= 2'd0;
            state_reg    <= SCAN;
            col_reg      <= 4'b1110;
            code_reg     <= 4'h0;
            valid_reg    <= 1'b0;
            held_reg     <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            slot_reg  <= slot_end ? '0 : slot_reg + 1'b1;
            if (slot_end) begin
                case (state_reg)
                    SCAN: begin
                        if (rc.hit) begin
                            cand_row_reg <= rc.row;
                            if (DB_MAX == 8'd1) begin
                                state_reg <= PRESSED;
                                code_reg  <= KEY_MAP[{rc.row, col_index(col_reg)}];
                                valid_reg <= 1'b1;
                                held_reg  <= 1'b1;
                                db_reg    <= 8'd0;
                            end else begin
                                state_reg <= CONFIRM;
                                db_reg    <= 8'd1;
                            end
                        end else begin
                            col_reg <= col_rotate(col_reg);
                        end
                    end
                    CONFIRM: begin
                        if (rc.hit && rc.row == cand_row_reg) begin
                            if (db_inc == DB_MAX) begin
                                state_reg <= PRESSED;
                                code_reg  <= KEY_MAP[{cand_row_reg, col_index(col_reg)}];
                                valid_reg <= 1'b1;
                                held_reg  <= 1'b1;
                                db_reg    <= 8'd0;
                            end else begin
                                db_reg <= db_inc;
                            end
                        end else begin
                            state_reg <= SCAN;
                            col_reg   <= col_rotate(col_reg);
                            db_reg    <= 8'd0;
                        end
                    end
                    PRESSED: begin
                        // Any hit on the locked column keeps the key held.
                        if (rc.hit) begin
                            db_reg <= 8'd0;
                        end else if (db_inc == DB_MAX) begin
                            state_reg <= SCAN;
                            held_reg  <= 1'b0;
                            col_reg   <= col_rotate(col_reg);
                            db_reg    <= 8'd0;
                        end else begin
                            db_reg <= db_inc;
                        end
                    end
                    default: begin
                        state_reg <= SCAN;
                        db_reg    <= 8'd0;
                    end
                endcase
            end
        end
    end

    assign col_n     = col_reg;
    assign key_code  = code_reg;
    assign key_valid = valid_reg;
    assign key_held  = held_reg;

endmodule

// File: tb/tb_keypad_encoder.sv
// Scoreboard bench for keypad_encoder: keypad model drives rows from col_n, monitors pop expected codes.
module tb_keypad_encoder;

    logic        clk = 1'b0;
    logic        rst_n, rst1_n;
    logic [3:0]  row_n, row1_n;
    logic [3:0]  col_n, col1_n, key_code, key1_code;
    logic        key_valid, key1_valid, key_held, key1_held;
    logic [15:0] press, press1;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp1_q[$];

    always #5 clk = ~clk;

    keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .row_n(row1_n), .col_n(col1_n),
        .key_code(key1_code), .key_valid(key1_valid), .key_held(key1_held)
    );

    // Key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_n  = 4'b1111;
        row1_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (press[r*4+c] && !col_n[c])   row_n[r]  = 1'b0;
                if (press1[r*4+c] && !col1_n[c]) row1_n[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [3:0] next_col(input logic [3:0] c);
        case (c)
            4'b1110: return 4'b1101;
            4'b1101: return 4'b1011;
            4'b1011: return 4'b0111;
            default: return 4'b1110;
        endcase
    endfunction

    logic prev_v  = 1'b0;
    logic prev_v1 = 1'b0;
    logic [3:0] e0, e1;

    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            check("valid_gap", {31'd0, prev_v}, 0);
            check("held_with_valid", {31'd0, key_held}, 1);
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_valid: got code %0h want no pulse", key_code);
            end else begin
                e0 = exp_q.pop_front();
                check("key_code", {28'd0, key_code}, {28'd0, e0});
            end
        end
        if (rst1_n && key1_valid) begin
            check("valid_gap_db1", {31'd0, prev_v1}, 0);
            if (exp1_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_valid_db1: got code %0h want no pulse", key1_code);
            end else begin
                e1 = exp1_q.pop_front();
                check("key_code_db1", {28'd0, key1_code}, {28'd0, e1});
            end
        end
        prev_v  = key_valid;
        prev_v1 = key1_valid;
    end

    // Wait until the selected DUT starts driving the target column.
    task automatic wait_fresh(input bit which, input logic [3:0] target);
        logic [3:0] prev;
        logic [3:0] cur;
        int n = 0;
        do begin
            prev = which ? col1_n : col_n;
            @(negedge clk);
            cur = which ? col1_n : col_n;
            n++;
        end while (!(cur == target && prev != target) && n < 200);
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL wait_col: got timeout want col %b", target);
        end
    endtask

    task automatic wait_held(input logic level, output int cycles);
        cycles = 0;
        while (key_held !== level && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 200) begin
            total++; bad++;
            $display("FAIL wait_held: got timeout want held=%0d", level);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev;
        int changes, since, n;

        rst_n = 1'b0; rst1_n = 1'b0; press = '0; press1 = '0;
        repeat (3) @(negedge clk);
        check("rst_col_n", {28'd0, col_n}, 4'b1110);
        check("rst_key_code", {28'd0, key_code}, 0);
        check("rst_key_valid", {31'd0, key_valid}, 0);
        check("rst_key_held", {31'd0, key_held}, 0);
        rst_n = 1'b1; rst1_n = 1'b1;

        // Test 1: idle rotation
        prev = col_n; changes = 0; since = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            since++;
            if (col_n != prev) begin
                check("rotate", {28'd0, col_n}, {28'd0, next_col(prev)});
                check("slot_len", since, 4);
                changes++; since = 0; prev = col_n;
            end
        end
        check("rotate_count", changes, 10);
        check("idle_key_code", {28'd0, key_code}, 0);

        // Test 2: clean press r1/c2
        wait_fresh(0, 4'b1011);
        press[6] = 1'b1;
        exp_q.push_back(4'h6);
        repeat (40) @(negedge clk);
        check("press_held", {31'd0, key_held}, 1);
        check("press_col_locked", {28'd0, col_n}, 4'b1011);

        // Test 3: release
        press = '0;
        wait_held(1'b0, n);
        check("release_window", {31'd0, (n >= 11 && n <= 14)}, 1);
        check("release_col_n", {28'd0, col_n}, 4'b0111);
        check("release_code_kept", {28'd0, key_code}, 4'h6);

        // Test 4: bounce on r3/c1 during CONFIRM
        wait_fresh(0, 4'b1101);
        press[13] = 1'b1;
        repeat (4) @(negedge clk);
        press[13] = 1'b0;
        repeat (2) @(negedge clk);
        press[13] = 1'b1;
        repeat (2) @(negedge clk);
        check("bounce_abort_col", {28'd0, col_n}, 4'b1011);
        check("bounce_abort_held", {31'd0, key_held}, 0);
        exp_q.push_back(4'h0);
        wait_held(1'b1, n);
        check("bounce_code", {28'd0, key_code}, 4'h0);
        press = '0;
        wait_held(1'b0, n);

        // Test 5: ghost r1+r2 on column 0
        wait_fresh(0, 4'b1110);
        press[4] = 1'b1; press[8] = 1'b1;
        prev = col_n; changes = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (col_n != prev) begin changes++; prev = col_n; end
        end
        check("ghost_rotates", changes, 6);
        check("ghost_not_held", {31'd0, key_held}, 0);
        press = '0;

        // Test 6: reset mid-CONFIRM on r0/c3
        wait_fresh(0, 4'b0111);
        press[3] = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_col_n", {28'd0, col_n}, 4'b1110);
        check("midrst_held", {31'd0, key_held}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        press = '0;
        wait_fresh(0, 4'b0111);
        press[3] = 1'b1;
        exp_q.push_back(4'hA);
        wait_held(1'b1, n);
        check("reaccept_code", {28'd0, key_code}, 4'hA);
        press = '0;
        wait_held(1'b0, n);

        // DEBOUNCE=1 variant accepts on the first hit
        wait_fresh(1, 4'b0111);
        press1[3] = 1'b1;
        exp1_q.push_back(4'hA);
        repeat (4) @(negedge clk);
        check("db1_first_hit", {31'd0, key1_held}, 1);
        press1 = '0;
        repeat (20) @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        check("scoreboard_empty_db1", exp1_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_encoder.md
Name: keypad_encoder

Overview:
- Scans a 4x4 matrix keypad and encodes the pressed key into a 4-bit hex code with a one-cycle valid strobe.
- It is the input-side counterpart of the segment decoders. Its key_code output feeds a BCD/hex register that a segment decoder then displays.
- Targets the icoboard 100 MHz clock.
- Handles synchronisation, column scanning, debounce, press/release tracking and ghost rejection.

Parameters:
- SCAN_DIV, 100000: clock cycles per column slot (1 ms at 100 MHz); must be at least 2.
- DEBOUNCE, 8: number of consecutive identical slot samples needed to accept a press, and also to accept a release; range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- row_n  in  4  keypad rows, active-low (external pull-ups), asynchronous to clk.
- col_n  out  4  column drive, one-hot-low; only one bit is 0 at any time.
- key_code  out  4  hex code of the last accepted key; holds its value until the next press.
- key_valid  out  1  one-cycle pulse when a press is accepted.
- key_held  out  1  high from acceptance until release is accepted.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - col_n=4'b1110, key_code=0, key_valid=0, key_held=0.
  - Synchroniser flops = 4'b1111, slot counter = 0, debounce counter = 0, state = SCAN.
- Synchroniser: row_n passes through 2 flops to give row_s. All decisions use only row_s.
- Slot timing:
  - The slot counter counts 0..SCAN_DIV-1 and then wraps.
  - The "sample point" is the cycle where the counter equals SCAN_DIV-1; row_s is evaluated only there.
  - col_n changes only on the cycle after a sample point.
- A sample is a "hit" when exactly one bit of row_s is 0. Zero low bits is "none". Two or more low bits is "ghost", which is treated as none.
- Key map, written as row r / col c -> code:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D  (* = E, # = F)
- FSM states:
  - SCAN:
    - A hit on column c latches cand = (r, c), clears the debounce counter to 1, and moves to CONFIRM with col_n held on c.
    - Otherwise col_n rotates left (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - CONFIRM (column locked):
    - A sample equal to cand increments the counter.
    - When the counter reaches DEBOUNCE, the FSM moves to PRESSED: key_code = map(cand), key_valid=1 for exactly one cycle, key_held=1.
    - Any other sample (a different row, none, or ghost) returns to SCAN and rotates to the next column.
    - With DEBOUNCE=1, the initial hit goes directly to PRESSED.
  - PRESSED (column locked):
    - A sample of none or ghost increments a release counter; a hit on any row resets it to 0.
    - When the release counter reaches DEBOUNCE, the FSM moves to SCAN, key_held=0, and col_n rotates to the next column.
    - A second key on the same column is ignored until release.
    - key_code is not changed.
- Latency:
  - Press stable at cycle T0 on the currently driven column. Sampled row_s reflects the press 2 cycles later.
  - key_valid rises 1 cycle after the DEBOUNCE-th matching sample point.
  - Worst case from a press to key_valid is (4 + DEBOUNCE) * SCAN_DIV + 3 cycles.
- Pulse width: key_valid is never high for two consecutive cycles.
- Mid-operation reset (rst_n asserted in any state): all state returns to reset values immediately. No key_valid is generated on deassertion.
- Bounce during CONFIRM restarts the scan. Bounce during PRESSED only delays release.

Decomposition:
- keypad_pkg:
  - State enum: SCAN, CONFIRM, PRESSED.
  - KEY_MAP constant (16 x 4-bit, indexed {r, c}).
  - Column rotate function.
  - hit/ghost classify function.
- Sub-module sync_2ff (parameterised width, asynchronous active-low reset to all-ones) for row_n.
- Everything else sits in keypad_encoder.

Test Plan (SCAN_DIV=4, DEBOUNCE=3 unless noted):
1. Reset with rows idle (row_n=1111) for 40 cycles -> col_n cycles 1110, 1101, 1011, 0111, changing every 4 cycles; key_valid never asserts; key_code=0.
2. Clean press of r1/c2 (row_n bit1 low while col_n=1011), held for 40 cycles -> exactly one key_valid pulse with key_code=6; key_held=1; col_n stays 1011 while held.
3. Release after test 2 -> key_held falls 1 cycle after the 3rd consecutive none sample; scanning resumes at col_n=0111; no extra key_valid.
4. Bounce: r3/c1 press drops for one sample during CONFIRM, then stays stable -> first attempt aborted with no key_valid; after rescan, key_valid is asserted once with key_code=0.
5. Ghost: two rows low (row_n=1001) on column 0 -> no key_valid; scan continues rotating.
6. Reset mid-CONFIRM (rst_n low 2 cycles while r0/c3 is pressed) -> col_n=1110 and key_held=0 immediately; after release, the key is re-accepted with key_code=A; DEBOUNCE=1 variant accepts on the first hit.
